// File: rtl/cmd_encoder_pkg.sv
// Shared byte encodings and types for the command encoder.
package cmd_encoder_pkg;

   localparam logic [7:0] START_BYTE = 8'h05;
   localparam logic [7:0] STOP_BYTE  = 8'h09;
   localparam logic [1:0] OP_SUFFIX  = 2'b10;
   localparam logic [1:0] TGT_SUFFIX = 2'b11;
   localparam logic [7:0] IDLE_BYTE  = 8'h00;

   localparam int unsigned NUM_BUTTONS = 5;

   typedef enum logic {
      GAME_STOPPED,
      GAME_STARTED
   } game_state_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_STATE,
      SRC_OP,
      SRC_TGT
   } push_src_t;

   function automatic logic [7:0] op_byte(input logic [4:0] bits);
      return {1'b0, bits, OP_SUFFIX};
   endfunction

   function automatic logic [7:0] tgt_byte(input logic [5:0] id);
      return {id, TGT_SUFFIX};
   endfunction

endpackage

// File: rtl/debouncer.sv
// Single-bit debouncer: the accepted level follows the raw input only after
// the raw input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 2400
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] count;

   // Count consecutive disagreeing cycles; any agreement restarts the count.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         level <= 1'b0;
      end else if (raw == level) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
         level <= raw;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/cmd_encoder.sv
// Turns debounced buttons and synchronised switches into command bytes,
// queues them in a small FIFO and presents the head to the UART.
module cmd_encoder
   import cmd_encoder_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2400,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [4:0]                    button,
   input  logic [7:0]                    switches,
   input  logic                          tx_ready,
   output logic [7:0]                    tx_byte,
   output logic                          started,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned LW     = AW + 1;
   localparam int unsigned SETTLE = DEBOUNCE_CYCLES + 3;
   localparam int unsigned SW     = $clog2(SETTLE + 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   logic unused_sw6;
   assign unused_sw6 = switches[6];

   // ---------------- input conditioning ----------------
   logic [4:0] btn_level, btn_prev;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
      debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
         .clock   (clock),
         .reset_n (reset_n),
         .raw     (button[i]),
         .level   (btn_level[i])
      );
   end

   logic       start_meta, start_sync, start_prev;
   logic [5:0] id_meta, id_sync, id_prev;
   logic [SW-1:0] settle_cnt;
   logic       armed;

   // Levels already present at reset release must not look like edges, so
   // edge detection stays disarmed until debouncers and synchronisers settle.
   assign armed = (settle_cnt == SW'(SETTLE));

   // Two-flop switch synchroniser, edge-history registers and settle counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_meta <= 1'b0;
         start_sync <= 1'b0;
         start_prev <= 1'b0;
         id_meta    <= '0;
         id_sync    <= '0;
         id_prev    <= '0;
         btn_prev   <= '0;
         settle_cnt <= '0;
      end else begin
         start_meta <= switches[7];
         start_sync <= start_meta;
         start_prev <= start_sync;
         id_meta    <= switches[5:0];
         id_sync    <= id_meta;
         id_prev    <= id_sync;
         btn_prev   <= btn_level;
         if (!armed) settle_cnt <= settle_cnt + SW'(1);
      end
   end

   logic       start_rise, start_fall, id_change;
   logic [4:0] btn_rise;

   assign start_rise = armed &  start_sync & ~start_prev;
   assign start_fall = armed & ~start_sync &  start_prev;
   assign id_change  = armed & (id_sync != id_prev);
   assign btn_rise   = armed ? (btn_level & ~btn_prev) : '0;

   // ---------------- game state FSM ----------------
   game_state_t state, state_next;
   logic        state_ev;
   logic [7:0]  state_ev_byte;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= GAME_STOPPED;
      else          state <= state_next;
   end

   // Next-state logic: start/stop edges only act in the matching state.
   always_comb begin
      state_next = state;
      case (state)
         GAME_STOPPED: if (start_rise) state_next = GAME_STARTED;
         GAME_STARTED: if (start_fall) state_next = GAME_STOPPED;
         default:      state_next = GAME_STOPPED;
      endcase
   end

   // Outputs: started flag and the state-change byte raised on a transition.
   always_comb begin
      started       = (state == GAME_STARTED);
      state_ev      = 1'b0;
      state_ev_byte = IDLE_BYTE;
      case (state)
         GAME_STOPPED: if (start_rise) begin
            state_ev      = 1'b1;
            state_ev_byte = START_BYTE;
         end
         GAME_STARTED: if (start_fall) begin
            state_ev      = 1'b1;
            state_ev_byte = STOP_BYTE;
         end
         default: ;
      endcase
   end

   // ---------------- pending events and push arbitration ----------------
   logic       st_pend;
   logic [7:0] st_pend_byte;
   logic [4:0] op_pend_bits;
   logic       tgt_pend;
   logic [5:0] tgt_pend_id;

   logic [4:0] op_ev_bits;
   logic       tgt_ev;
   logic       eff_st, eff_tgt;
   logic [7:0] eff_st_byte;
   logic [4:0] eff_op_bits;
   logic [5:0] eff_tgt_id;
   push_src_t  push_src;
   logic [7:0] push_byte;

   assign op_ev_bits = started ? btn_rise : '0;
   assign tgt_ev     = started & id_change;

   // New events merge with their class's pending register so an event can be
   // pushed in the cycle it appears; the winner's pending entry is consumed.
   always_comb begin
      eff_st      = st_pend | state_ev;
      eff_st_byte = state_ev ? state_ev_byte : st_pend_byte;
      eff_op_bits = op_pend_bits | op_ev_bits;
      eff_tgt     = tgt_pend | tgt_ev;
      eff_tgt_id  = tgt_ev ? id_sync : tgt_pend_id;
      push_src    = SRC_NONE;
      push_byte   = IDLE_BYTE;
      if (eff_st) begin
         push_src  = SRC_STATE;
         push_byte = eff_st_byte;
      end else if (|eff_op_bits) begin
         push_src  = SRC_OP;
         push_byte = op_byte(eff_op_bits);
      end else if (eff_tgt) begin
         push_src  = SRC_TGT;
         push_byte = tgt_byte(eff_tgt_id);
      end
   end

   // Pending registers hold whatever lost arbitration this cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         st_pend      <= 1'b0;
         st_pend_byte <= IDLE_BYTE;
         op_pend_bits <= '0;
         tgt_pend     <= 1'b0;
         tgt_pend_id  <= '0;
      end else begin
         st_pend      <= eff_st & (push_src != SRC_STATE);
         st_pend_byte <= eff_st_byte;
         op_pend_bits <= (push_src == SRC_OP) ? '0 : eff_op_bits;
         tgt_pend     <= eff_tgt & (push_src != SRC_TGT);
         tgt_pend_id  <= eff_tgt_id;
      end
   end

   // ---------------- command FIFO ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [LW-1:0] level_next;
   logic [7:0]    head_next;
   logic          push_req, push, pop, drop, drained;

   assign pop      = tx_ready & (fifo_level != '0);
   assign push_req = (push_src != SRC_NONE);
   assign push     = push_req & ((fifo_level != FULL_LEVEL) | pop);
   assign drop     = push_req & ~push;
   assign drained  = (fifo_level == '0) | (pop & (fifo_level == LW'(1)));

   // Storage write; contents need no reset since level gates visibility.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_byte;
   end

   // Next level and next head; a byte pushed into an empty (or emptying)
   // queue becomes the head directly since it is not yet in storage.
   always_comb begin
      level_next = fifo_level;
      if (push & ~pop)      level_next = fifo_level + LW'(1);
      else if (pop & ~push) level_next = fifo_level - LW'(1);
      rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;
      if (level_next == '0) head_next = IDLE_BYTE;
      else if (drained)     head_next = push_byte;
      else                  head_next = mem[rd_next];
   end

   // FIFO pointers, level, registered head and sticky overflow.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         tx_byte    <= IDLE_BYTE;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr     <= rd_next;
         fifo_level <= level_next;
         tx_byte    <= head_next;
         if (drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cmd_encoder.sv
// Self-checking bench for cmd_encoder: directed scenarios plus a randomized
// action loop checked against an event-level queue model.
module tb_cmd_encoder;

   localparam int unsigned DB    = 16;
   localparam int unsigned DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] button = '0;
   logic [7:0] switches = '0;
   logic       tx_ready = 1'b0;
   logic [7:0] tx_byte;
   logic       started;
   logic [2:0] fifo_level;
   logic       overflow;

   cmd_encoder #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .button     (button),
      .switches   (switches),
      .tx_ready   (tx_ready),
      .tx_byte    (tx_byte),
      .started    (started),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model: queued bytes, game flag, sticky overflow.
   logic [7:0] q[$];
   bit         m_started;
   bit         m_overflow;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic model_push(input logic [7:0] b);
      if (q.size() == DEPTH) m_overflow = 1'b1;
      else q.push_back(b);
   endtask

   task automatic check_state(input string tag);
      logic [7:0] head;
      head = (q.size() != 0) ? q[0] : 8'h00;
      check({tag, ".level"},    32'(fifo_level), 32'(q.size()));
      check({tag, ".tx_byte"},  32'(tx_byte),    32'(head));
      check({tag, ".started"},  32'(started),    32'(m_started));
      check({tag, ".overflow"}, 32'(overflow),   32'(m_overflow));
   endtask

   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      check("reset.tx_byte",  32'(tx_byte),    32'h00);
      check("reset.level",    32'(fifo_level), 32'h0);
      check("reset.started",  32'(started),    32'h0);
      check("reset.overflow", 32'(overflow),   32'h0);
      q.delete();
      m_started  = 1'b0;
      m_overflow = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(DB + 10);
   endtask

   task automatic pop_one();
      tx_ready = 1'b1;
      tick(1);
      tx_ready = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic toggle_start();
      logic v;
      v = ~switches[7];
      switches[7] = v;
      tick(DB + 8);
      if (v && !m_started) begin
         model_push(8'h05);
         m_started = 1'b1;
      end else if (!v && m_started) begin
         model_push(8'h09);
         m_started = 1'b0;
      end
   endtask

   task automatic set_target(input logic [5:0] id);
      if (id != switches[5:0]) begin
         switches[5:0] = id;
         tick(DB + 8);
         if (m_started) model_push({id, 2'b11});
      end
   endtask

   // Bounce the button for roughly bounce_cycles with short glitches, then a
   // clean press and release.
   task automatic press(input int unsigned i, input int unsigned bounce_cycles);
      int unsigned spent;
      logic [7:0] ob;
      spent = 0;
      while (spent < bounce_cycles) begin
         int unsigned w;
         w = $urandom_range(1, 6);
         button[i] = ~button[i];
         tick(w);
         spent += w;
      end
      button[i] = 1'b1;
      tick(DB + 4);
      button[i] = 1'b0;
      tick(DB + 6);
      ob = (8'd1 << (i + 2)) | 8'h02;
      if (m_started) model_push(ob);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;

      // Reset and first start command latency.
      do_reset();
      check_state("idle");
      switches[7] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         if (!found && tx_byte == 8'h05) found = 1'b1;
      end
      check("start.latency", 32'(found), 32'h1);
      m_started = 1'b1;
      model_push(8'h05);
      tick(DB);
      check_state("start");
      pop_one();
      check_state("start.popped");

      // Bouncy button press yields exactly one operate byte.
      press(2, 100);
      check_state("bounce");
      pop_one();
      check_state("bounce.popped");

      // Stop, then operate/target activity while stopped is discarded.
      toggle_start();
      check_state("stop");
      pop_one();
      press(0, 10);
      set_target(6'd9);
      check_state("stopped.discard");

      // Six fast target changes while started overflow a 4-deep queue.
      toggle_start();
      pop_one();
      for (int k = 1; k <= 6; k++) begin
         switches[5:0] = 6'(k);
         tick(10);
         model_push({6'(k), 2'b11});
      end
      tick(DB);
      check_state("overflow");

      // Reset with start switch and target already high: no events afterwards.
      do_reset();
      check_state("post_reset.quiet");
      toggle_start();
      check_state("post_reset.fall");
      toggle_start();
      pop_one();
      check_state("restart");

      // Button edge and target change in the same cycle: operate first.
      button[1] = 1'b1;
      tick(DB - 2);
      switches[5:0] = 6'd5;
      tick(DB + 6);
      button[1] = 1'b0;
      tick(DB + 6);
      model_push(8'h0A);
      model_push(8'h17);
      check_state("collide");
      pop_one();
      check_state("collide.second");
      pop_one();

      // Full queue: push and pop in the same cycle both take effect.
      set_target(6'd1);
      set_target(6'd2);
      set_target(6'd3);
      set_target(6'd4);
      check_state("full");
      switches[5:0] = 6'd7;
      tick(2);
      tx_ready = 1'b1;
      tick(1);
      tx_ready = 1'b0;
      void'(q.pop_front());
      model_push(8'h1F);
      tick(4);
      check_state("full.push_pop");

      // Reset mid-queue drops everything immediately.
      do_reset();
      check_state("mid_reset");

      // Randomized actions against the model.
      for (int it = 0; it < 40; it++) begin
         int unsigned act;
         act = $urandom_range(0, 19);
         if (act == 0)       do_reset();
         else if (act < 5)   toggle_start();
         else if (act < 9)   set_target(6'($urandom_range(0, 63)));
         else if (act < 13)  press($urandom_range(0, 4), $urandom_range(0, 20));
         else                pop_one();
         check_state("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cmd_encoder.md
CMD_ENCODER -- requirements
Module: cmd_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2400, meaning stable cycles before a button level is accepted (about 15.6 ms at 153.6 kHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning command queue entries; it SHALL be a power of two.
REQ-003 SHALL have port clock  input  1  the UART 16x clock, sole clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port button  input  5  raw push buttons, active-high.
REQ-006 SHALL have port switches  input  8  bit 7 is start/stop; bits 5:0 are the target ID; bit 6 is unused.
REQ-007 SHALL have port tx_ready  input  1  one-cycle pulse from UART: the current byte has been transmitted.
REQ-008 SHALL have port tx_byte  output  8  byte presented to the UART io_dataIn_bits input.
REQ-009 SHALL have port started  output  1  game-started flag.
REQ-010 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued bytes.
REQ-011 SHALL have port overflow  output  1  sticky flag: a command was dropped.

Function
REQ-012 Each button bit SHALL be debounced: the accepted level changes only after the raw level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that bit's counter.
REQ-013 A 0->1 transition of an accepted button i SHALL raise an operate event with byte {1'b0, onehot(i)[4:0], 2'b10}.
REQ-014 switches[7] SHALL pass through a 2-flop synchroniser; a rising edge while started=0 SHALL raise byte 8'h05 and set started; a falling edge while started=1 SHALL raise byte 8'h09 and clear started.
REQ-015 A change of synchronised switches[5:0] while started=1 SHALL raise a target event with byte {switches[5:0], 2'b11}.
REQ-016 Operate and target events raised while started=0 SHALL be discarded silently.
REQ-017 Each event class (state, operate, target) SHALL have one pending register. At most one FIFO push SHALL occur per cycle, with priority state > operate > target. A pending class SHALL wait until it is the highest-priority pending class.
REQ-018 A new operate event arriving while an operate event is still pending SHALL OR its one-hot bits into the pending byte; a new target event SHALL overwrite the pending target byte.
REQ-019 If a push is attempted while the FIFO is full, the byte SHALL be dropped, its pending register SHALL be cleared, and overflow SHALL be set; overflow clears only on reset.
REQ-020 tx_byte SHALL equal the FIFO head when fifo_level>0, and 8'h00 (idle) when empty; it SHALL be driven from a register.
REQ-021 tx_ready=1 with fifo_level>0 SHALL pop the head; the next head SHALL appear on tx_byte on the following cycle. tx_ready while the FIFO is empty SHALL be ignored.
REQ-022 If a push and a pop occur in the same cycle, both SHALL take effect and fifo_level SHALL be unchanged; a push while full with a simultaneous pop SHALL succeed.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 When reset_n=0, the following SHALL clear asynchronously: tx_byte=8'h00, started=0, fifo_level=0, overflow=0, all pending registers, all debounce counters, accepted levels=0, and synchroniser flops=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued bytes; after release, no event SHALL be raised for switch or button levels that are already high until they toggle.

Structure
REQ-026 The byte encodings SHALL be constants in a shared package: START=8'h05, STOP=8'h09, channel suffixes OP=2'b10 and TGT=2'b11, IDLE=8'h00.
REQ-027 Debouncing SHALL be a sub-module, debouncer (1 bit, parameter DEBOUNCE_CYCLES), instantiated five times.
REQ-028 The FIFO SHALL be implemented inline; the block SHALL contain no other sub-modules.

Verification
REQ-029 Scenario: reset, then switches[7] 0->1, then tx_ready pulse -> tx_byte=8'h05 appears within 4 cycles, started=1; after the pulse, tx_byte=8'h00 and fifo_level=0.
REQ-030 Scenario: started=1, button[2] bounces for 100 cycles then holds high for DEBOUNCE_CYCLES -> exactly one byte 8'h12 is queued.
REQ-031 Scenario: started=0, press button[0] and change switches[5:0] -> nothing is queued; fifo_level=0.
REQ-032 Scenario: started=1, no tx_ready, six target changes 1..6 issued 10 cycles apart -> FIFO holds {8'h07, 8'h0B, 8'h0F, 8'h13}, overflow=1, fifo_level=4.
REQ-033 Scenario: started=1, button[1] edge and switches[5:0]=5 in the same cycle -> bytes 8'h0A then 8'h17 are queued in that order.
REQ-034 Scenario: FIFO full, push and tx_ready in the same cycle -> fifo_level stays 4, overflow stays 0; reset_n low mid-queue -> tx_byte=8'h00 immediately.
